// File: rtl/vote_tally_reader.sv
// rtl/vote_tally_reader.sv - readout sequencer that captures the voting machine tallies
module vote_tally_reader #(
  parameter int HOLD_CYCLES   = 10,
  parameter int SAMPLE_OFFSET = 8,
  parameter int GAP_CYCLES    = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] led_in,
  output logic       mode_out,
  output logic       button1_out,
  output logic       button2_out,
  output logic       button3_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] count1,
  output logic [7:0] count2,
  output logic [7:0] count3,
  output logic [1:0] winner,
  output logic       tie
);

  // One counter serves both the press and gap phases, so size it for the longer one.
  localparam int MAX_PHASE = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW        = $clog2(MAX_PHASE) + 1;

  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_OFFSET - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PRESS,
    S_GAP,
    S_DECIDE,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    cand_q, cand_d;     // candidate index 0..2 for buttons 1..3
  logic [CW-1:0] cnt_q, cnt_d;       // cycles spent in the current press/gap

  logic          mode_d;
  logic [2:0]    buttons_q, buttons_d;
  logic          busy_d;
  logic          done_d;

  logic          accept;
  logic          capture;
  logic [1:0]    winner_d;
  logic          tie_d;

  assign button1_out = buttons_q[0];
  assign button2_out = buttons_q[1];
  assign button3_out = buttons_q[2];

  assign accept  = (state_q == S_IDLE) && start;
  assign capture = (state_q == S_PRESS) && (cnt_q == SAMPLE_LAST);

  // Next-state logic: walk SETUP, three press/gap pairs, DECIDE and DONE.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        state_d = S_PRESS;
        cand_d  = 2'd0;
        cnt_d   = '0;
      end
      S_PRESS: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (cand_q == 2'd2) begin
            state_d = S_DECIDE;
          end else begin
            state_d = S_PRESS;
            cand_d  = cand_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DECIDE: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cand_d  = 2'd0;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the upcoming state so the control outputs come straight from flops.
  always_comb begin
    mode_d    = 1'b0;
    buttons_d = 3'b000;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    if ((state_d == S_SETUP) || (state_d == S_PRESS) || (state_d == S_GAP)) begin
      mode_d = 1'b1;
    end
    if (state_d == S_PRESS) begin
      buttons_d = 3'b001 << cand_d;
    end
  end

  // Result decode: a strict maximum names a winner; a shared nonzero maximum is a tie.
  always_comb begin
    winner_d = 2'd0;
    tie_d    = 1'b0;
    if ((count1 > count2) && (count1 > count3)) begin
      winner_d = 2'd1;
    end else if ((count2 > count1) && (count2 > count3)) begin
      winner_d = 2'd2;
    end else if ((count3 > count1) && (count3 > count2)) begin
      winner_d = 2'd3;
    end else if ((count1 != 8'd0) || (count2 != 8'd0) || (count3 != 8'd0)) begin
      tie_d = 1'b1;
    end
  end

  // Sequencer state and registered control outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cand_q    <= 2'd0;
      cnt_q     <= '0;
      mode_out  <= 1'b0;
      buttons_q <= 3'b000;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      mode_out  <= mode_d;
      buttons_q <= buttons_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Tally capture: clear on an accepted start, latch led_in once per press.
  always_ff @(posedge clock) begin
    if (reset || accept) begin
      count1 <= 8'd0;
      count2 <= 8'd0;
      count3 <= 8'd0;
    end else if (capture) begin
      case (cand_q)
        2'd0:    count1 <= led_in;
        2'd1:    count2 <= led_in;
        default: count3 <= led_in;
      endcase
    end
  end

  // Winner/tie: clear on an accepted start, load at the close of DECIDE, then hold.
  always_ff @(posedge clock) begin
    if (reset || accept) begin
      winner <= 2'd0;
      tie    <= 1'b0;
    end else if (state_q == S_DECIDE) begin
      winner <= winner_d;
      tie    <= tie_d;
    end
  end

endmodule

// File: tb/tb_vote_tally_reader.sv
// tb/tb_vote_tally_reader.sv - self-checking bench for vote_tally_reader
`timescale 1ns/1ps
module tb_vote_tally_reader;

  localparam int H   = 10;
  localparam int G   = 4;
  localparam int SA  = 8;
  localparam int SB  = 1;
  localparam int LAT = 2 + 3 * (H + G);

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;

  logic [7:0] led_a, led_b;
  logic       mode_a, b1_a, b2_a, b3_a, busy_a, done_a, tie_a;
  logic       mode_b, b1_b, b2_b, b3_b, busy_b, done_b, tie_b;
  logic [7:0] c1_a, c2_a, c3_a, c1_b, c2_b, c3_b;
  logic [1:0] win_a, win_b;

  logic [7:0] t1 = 8'd0, t2 = 8'd0, t3 = 8'd0;
  bit         sp_only = 1'b0;
  int         pidx_a = 1, pidx_b = 1;

  int compared = 0;
  int mism     = 0;

  typedef struct {
    logic [7:0] a, b, c;
    int         w, t;
  } vec_t;
  vec_t tbl[8];

  always #5 clock = ~clock;

  vote_tally_reader #(.HOLD_CYCLES(H), .SAMPLE_OFFSET(SA), .GAP_CYCLES(G)) u_dut_a (
    .clock(clock), .reset(reset), .start(start), .led_in(led_a),
    .mode_out(mode_a), .button1_out(b1_a), .button2_out(b2_a), .button3_out(b3_a),
    .busy(busy_a), .done(done_a), .count1(c1_a), .count2(c2_a), .count3(c3_a),
    .winner(win_a), .tie(tie_a));

  vote_tally_reader #(.HOLD_CYCLES(H), .SAMPLE_OFFSET(SB), .GAP_CYCLES(G)) u_dut_b (
    .clock(clock), .reset(reset), .start(start), .led_in(led_b),
    .mode_out(mode_b), .button1_out(b1_b), .button2_out(b2_b), .button3_out(b3_b),
    .busy(busy_b), .done(done_b), .count1(c1_b), .count2(c2_b), .count3(c3_b),
    .winner(win_b), .tie(tie_b));

  // Voting machine display: the pressed candidate's tally in result mode.
  // In sample-only mode the true tally is shown only in the expected press cycle.
  function automatic logic [7:0] machine_led(input logic m, input logic [2:0] b, input int pidx,
                                             input int at, input bit only,
                                             input logic [7:0] v1, input logic [7:0] v2,
                                             input logic [7:0] v3);
    logic [7:0] shown;
    shown = only ? 8'hFF : 8'h00;
    if (m && b[0]) shown = (!only || pidx == at) ? v1 : 8'hFF;
    if (m && b[1]) shown = (!only || pidx == at) ? v2 : 8'hFF;
    if (m && b[2]) shown = (!only || pidx == at) ? v3 : 8'hFF;
    return shown;
  endfunction

  assign led_a = machine_led(mode_a, {b3_a, b2_a, b1_a}, pidx_a, SA, sp_only, t1, t2, t3);
  assign led_b = machine_led(mode_b, {b3_b, b2_b, b1_b}, pidx_b, SB, sp_only, t1, t2, t3);

  // Press-cycle index (1-based) seen by the machine while a button is held.
  always @(posedge clock) begin
    pidx_a <= (b1_a | b2_a | b3_a) ? pidx_a + 1 : 1;
    pidx_b <= (b1_b | b2_b | b3_b) ? pidx_b + 1 : 1;
  end

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mism++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Protocol invariants on both instances every cycle.
  always @(negedge clock) begin
    check("onehot_a", int'($onehot0({b3_a, b2_a, b1_a})), 1);
    check("btn_mode_a", int'((b1_a | b2_a | b3_a) && !mode_a), 0);
    check("onehot_b", int'($onehot0({b3_b, b2_b, b1_b})), 1);
    check("btn_mode_b", int'((b1_b | b2_b | b3_b) && !mode_b), 0);
  end

  // Reference result from the tallies: strict maximum wins, shared nonzero maximum ties.
  function automatic void ref_result(input int a, input int b, input int c,
                                     output int w, output int t);
    int mx, n;
    mx = a;
    if (b > mx) mx = b;
    if (c > mx) mx = c;
    n = int'(a == mx) + int'(b == mx) + int'(c == mx);
    if (mx == 0) begin
      w = 0; t = 0;
    end else if (n > 1) begin
      w = 0; t = 1;
    end else begin
      w = (a == mx) ? 1 : ((b == mx) ? 2 : 3);
      t = 0;
    end
  endfunction

  task automatic do_run(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input bit only, input bit spurious, input int ew, input int et);
    int done_at, dones_a, dones_b, busy_bad, idle_bad;
    t1 = a; t2 = b; t3 = c; sp_only = only;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    done_at = -1; dones_a = 0; dones_b = 0; busy_bad = 0; idle_bad = 0;
    for (int n = 1; n <= LAT + 6; n++) begin
      @(negedge clock);
      start = spurious && (n == 10 || n == LAT);
      if (done_a) begin
        dones_a++;
        if (done_at < 0) done_at = n;
      end
      if (done_b) dones_b++;
      if (n <= LAT && (!busy_a || !busy_b)) busy_bad++;
      if (n > LAT && (busy_a || busy_b)) idle_bad++;
    end
    start = 1'b0;
    check("done_at", done_at, LAT);
    check("done_count_a", dones_a, 1);
    check("done_count_b", dones_b, 1);
    check("busy_during", busy_bad, 0);
    check("idle_after", idle_bad, 0);
    check("count1_a", c1_a, a);
    check("count2_a", c2_a, b);
    check("count3_a", c3_a, c);
    check("count1_b", c1_b, a);
    check("count2_b", c2_b, b);
    check("count3_b", c3_b, c);
    check("winner_a", win_a, ew);
    check("tie_a", tie_a, et);
    check("winner_b", win_b, ew);
    check("tie_b", tie_b, et);
  endtask

  initial begin
    int w, t, first, second, idle, dones;
    logic [7:0] ra, rb, rc;

    tbl[0] = '{8'd5,   8'd3,   8'd7,   3, 0};
    tbl[1] = '{8'd4,   8'd4,   8'd2,   0, 1};
    tbl[2] = '{8'd9,   8'd9,   8'd9,   0, 1};
    tbl[3] = '{8'd0,   8'd0,   8'd0,   0, 0};
    tbl[4] = '{8'd0,   8'd0,   8'd1,   3, 0};
    tbl[5] = '{8'd200, 8'd199, 8'd0,   1, 0};
    tbl[6] = '{8'd255, 8'd0,   8'd255, 0, 1};
    tbl[7] = '{8'd0,   8'd7,   8'd0,   2, 0};

    repeat (10) @(negedge clock);
    check("rst_mode", mode_a, 0);
    check("rst_buttons", {b3_a, b2_a, b1_a}, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_counts", {c1_a, c2_a, c3_a}, 0);
    check("rst_winner_tie", {win_a, tie_a}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 8; i++) begin
      do_run(tbl[i].a, tbl[i].b, tbl[i].c, 1'b0, 1'b0, tbl[i].w, tbl[i].t);
    end

    do_run(8'd5, 8'd3, 8'd7, 1'b1, 1'b0, 3, 0);
    do_run(8'h10, 8'h30, 8'h20, 1'b1, 1'b0, 2, 0);
    do_run(8'd6, 8'd1, 8'd6, 1'b0, 1'b1, 0, 1);

    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        ra = 8'($urandom_range(0, 3));
        rb = 8'($urandom_range(0, 3));
        rc = 8'($urandom_range(0, 3));
      end else begin
        ra = 8'($urandom_range(0, 255));
        rb = 8'($urandom_range(0, 255));
        rc = 8'($urandom_range(0, 255));
      end
      ref_result(ra, rb, rc, w, t);
      do_run(ra, rb, rc, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), w, t);
    end

    // Reset in the middle of a readout, after candidate 1 has been captured.
    t1 = 8'd11; t2 = 8'd22; t3 = 8'd33; sp_only = 1'b0;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (19) @(negedge clock);
    reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    check("mid_rst_mode", mode_a, 0);
    check("mid_rst_buttons", {b3_a, b2_a, b1_a}, 0);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_done", done_a, 0);
    check("mid_rst_count1_a", c1_a, 0);
    check("mid_rst_count1_b", c1_b, 0);
    dones = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clock);
      if (done_a || done_b) dones++;
    end
    check("mid_rst_no_done", dones, 0);
    do_run(8'd11, 8'd22, 8'd33, 1'b0, 1'b0, 3, 0);

    // Start held high: back-to-back runs separated by a single idle cycle.
    t1 = 8'd1; t2 = 8'd2; t3 = 8'd2; sp_only = 1'b0;
    @(negedge clock); start = 1'b1;
    first = -1; second = -1; idle = 0;
    for (int n = 0; n <= 3 * LAT && second < 0; n++) begin
      @(negedge clock);
      if (done_a) begin
        if (first < 0) first = n;
        else second = n;
      end
      if (first >= 0 && second < 0 && !busy_a) idle++;
    end
    start = 1'b0;
    check("cont_first_done", first, LAT);
    check("cont_period", second - first, LAT + 2);
    check("cont_idle_cycles", idle, 1);
    check("cont_winner", win_a, 0);
    check("cont_tie", tie_a, 1);
    repeat (3) @(negedge clock);
    check("cont_stopped", busy_a, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
